// File: rtl/serial_cmp_pkg.sv
// Shared types for the serial compare scheduler.
//   sched_state_t : scheduler FSM states
//   cmp_t         : running MSB-first compare verdict held by the core
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } sched_state_t;

  typedef enum logic [1:0] {
    CMP_EQ,
    CMP_LESS,
    CMP_GREATER
  } cmp_t;

endpackage

// File: rtl/serial_comparator_msb_core.sv
// MSB-first bit-serial magnitude comparator.
// Ports:
//   clk, rst (async, active-low)
//   clear        : restart the compare at CMP_EQ (wins over en)
//   en           : consume one bit pair (a, b) this cycle
//   a, b         : current bit pair, most significant bit first
//   a_less_b, a_eq_b, a_greater_b : one-hot registered verdict
module serial_comparator_msb_core
  import serial_cmp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic a_less_b,
  output logic a_eq_b,
  output logic a_greater_b
);

  cmp_t cmp_q;

  // Once decided, the verdict is frozen: the first differing bit wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_q <= CMP_EQ;
    end else if (clear) begin
      cmp_q <= CMP_EQ;
    end else if (en && (cmp_q == CMP_EQ) && (a != b)) begin
      cmp_q <= a ? CMP_GREATER : CMP_LESS;
    end
  end

  always_comb begin
    a_less_b    = (cmp_q == CMP_LESS);
    a_eq_b      = (cmp_q == CMP_EQ);
    a_greater_b = (cmp_q == CMP_GREATER);
  end

endmodule

// File: rtl/serial_compare_scheduler.sv
// Round-robin scheduler sharing one MSB-first serial comparator between two
// requesters.
// Ports:
//   clk, rst (async, active-low)
//   reqN_valid/reqN_ready/reqN_a/reqN_b : operand pair handshake, N = 0, 1
//   res_valid/res_ready                 : result handshake
//   res_id                              : requester owning the result
//   res_less/res_eq/res_greater         : one-hot verdict, 0 when res_valid = 0
//   busy                                : scheduler not idle
module serial_compare_scheduler
  import serial_cmp_pkg::*;
#(
  parameter int unsigned W          = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_id,
  output logic         res_less,
  output logic         res_eq,
  output logic         res_greater,
  output logic         busy
);

  localparam int unsigned CntW = $clog2(W);

  sched_state_t  state_q;
  logic [CntW-1:0] cnt_q;
  logic [W-1:0]  a_q, b_q;
  logic          id_q;
  logic          last_grant_q;
  logic          res_valid_q;

  logic grant;
  logic core_clear, core_en;
  logic core_less, core_eq, core_greater;
  logic bit_a, bit_b;
  logic last_bit;

  always_comb begin
    // Contention alternates; a lone requester is granted directly.
    grant      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    req0_ready = rst && (state_q == IDLE) && req0_valid && !grant;
    req1_ready = rst && (state_q == IDLE) && req1_valid && grant;
    core_clear = (state_q == IDLE) && (req0_valid || req1_valid);
    core_en    = (state_q == SHIFT);
    bit_a      = a_q[W-1];
    bit_b      = b_q[W-1];
    // Early exit looks at the bit being fed now so the decision costs no
    // extra cycle beyond the edge that records it in the core.
    last_bit   = (cnt_q == '0) || (EARLY_EXIT && core_eq && (bit_a != bit_b));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      res_valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            a_q          <= grant ? req1_a : req0_a;
            b_q          <= grant ? req1_b : req0_b;
            id_q         <= grant;
            last_grant_q <= grant;
            cnt_q        <= CntW'(W - 1);
            state_q      <= SHIFT;
          end
        end
        SHIFT: begin
          a_q   <= {a_q[W-2:0], 1'b0};
          b_q   <= {b_q[W-2:0], 1'b0};
          cnt_q <= cnt_q - CntW'(1);
          if (last_bit) begin
            state_q     <= DONE;
            res_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  serial_comparator_msb_core u_core (
    .clk         (clk),
    .rst         (rst),
    .clear       (core_clear),
    .en          (core_en),
    .a           (bit_a),
    .b           (bit_b),
    .a_less_b    (core_less),
    .a_eq_b      (core_eq),
    .a_greater_b (core_greater)
  );

  // Core holds its verdict through DONE (en is low), so gating its flops
  // with res_valid gives stable, zero-when-idle outputs.
  always_comb begin
    res_valid   = res_valid_q;
    res_id      = res_valid_q & id_q;
    res_less    = res_valid_q & core_less;
    res_eq      = res_valid_q & core_eq;
    res_greater = res_valid_q & core_greater;
    busy        = (state_q != IDLE);
  end

endmodule

// File: tb/tb_serial_compare_scheduler.sv
// Directed bench for serial_compare_scheduler: one EARLY_EXIT=1 instance (dut)
// and one EARLY_EXIT=0 instance (dut_ne) driven independently.
module tb_serial_compare_scheduler;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic res_valid, res_ready, res_id, res_less, res_eq, res_greater, busy;

  logic n_req0_valid, n_req0_ready, n_req1_valid, n_req1_ready;
  logic [7:0] n_req0_a, n_req0_b, n_req1_a, n_req1_b;
  logic n_res_valid, n_res_ready, n_res_id, n_res_less, n_res_eq, n_res_greater, n_busy;

  int passed = 0;
  int total = 0;
  int both_err = 0;

  always #5 clk = ~clk;

  serial_compare_scheduler #(.W(8), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_less(res_less),
    .res_eq(res_eq), .res_greater(res_greater), .busy(busy)
  );

  serial_compare_scheduler #(.W(8), .EARLY_EXIT(1'b0)) dut_ne (
    .clk(clk), .rst(rst),
    .req0_valid(n_req0_valid), .req0_ready(n_req0_ready), .req0_a(n_req0_a),
    .req0_b(n_req0_b),
    .req1_valid(n_req1_valid), .req1_ready(n_req1_ready), .req1_a(n_req1_a),
    .req1_b(n_req1_b),
    .res_valid(n_res_valid), .res_ready(n_res_ready), .res_id(n_res_id),
    .res_less(n_res_less), .res_eq(n_res_eq), .res_greater(n_res_greater), .busy(n_busy)
  );

  always @(negedge clk) if (req0_ready && req1_ready) both_err++;

  function automatic logic cur_ready(input int who);
    case (who)
      0: return req0_ready;
      1: return req1_ready;
      default: return n_req0_ready;
    endcase
  endfunction

  // Present a pair, wait (bounded) for ready, let the accept edge pass and
  // drop valid. Returns at 1 time unit after the accept edge.
  task automatic issue(input int who, input logic [7:0] a, input logic [7:0] b,
                       output logic rdy_first);
    int k;
    k = 0;
    case (who)
      0: begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
      1: begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
      default: begin n_req0_a = a; n_req0_b = b; n_req0_valid = 1'b1; end
    endcase
    #1;
    rdy_first = cur_ready(who);
    while (!cur_ready(who) && k < 20) begin
      @(posedge clk); #1; k++;
    end
    @(posedge clk); #1;
    case (who)
      0: req0_valid = 1'b0;
      1: req1_valid = 1'b0;
      default: n_req0_valid = 1'b0;
    endcase
  endtask

  // Count edges from the accept edge until res_valid (bounded at 40).
  task automatic wait_res(input int inst, output int n);
    n = 0;
    while (!(inst == 0 ? res_valid : n_res_valid) && n < 40) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else passed++;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22;
    rst = 1'b0;
    step(); step();
    total++; if (req0_ready !== 1'b0) $display("FAIL rst_ready: got %b expected 0", req0_ready); else passed++;
    total++; if (res_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", res_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else passed++;
    total++;
    if ({res_id, res_less, res_eq, res_greater} !== 4'b0)
      $display("FAIL rst_res: got %b expected 0000", {res_id, res_less, res_eq, res_greater});
    else passed++;
    req0_valid = 1'b0;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_greater_early();
    logic r; int n;
    issue(0, 8'h64, 8'h62, r);
    total++; if (r !== 1'b1) $display("FAIL t1_ready: got %b expected 1", r); else passed++;
    wait_res(0, n);
    total++; if (n != 6) $display("FAIL t1_latency: got %0d expected 6", n); else passed++;
    total++;
    if ({res_less, res_eq, res_greater} !== 3'b001)
      $display("FAIL t1_result: got %b expected 001", {res_less, res_eq, res_greater});
    else passed++;
    total++; if (res_id !== 1'b0) $display("FAIL t1_id: got %b expected 0", res_id); else passed++;
    step();
  endtask

  task automatic test_equal_req1();
    logic r; int n;
    issue(1, 8'hA5, 8'hA5, r);
    wait_res(0, n);
    total++; if (n != 8) $display("FAIL t2_latency: got %0d expected 8", n); else passed++;
    total++;
    if ({res_less, res_eq, res_greater} !== 3'b010)
      $display("FAIL t2_result: got %b expected 010", {res_less, res_eq, res_greater});
    else passed++;
    total++; if (res_id !== 1'b1) $display("FAIL t2_id: got %b expected 1", res_id); else passed++;
    step();
  endtask

  task automatic test_arbitration();
    int n;
    for (int round = 0; round < 2; round++) begin
      if (round == 0) apply_reset();
      req0_a = 8'h03; req0_b = 8'h07; req1_a = 8'h09; req1_b = 8'h08;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      total++;
      if ({req0_ready, req1_ready} !== 2'b10)
        $display("FAIL t3_grant0 r%0d: got %b expected 10", round, {req0_ready, req1_ready});
      else passed++;
      step();
      req0_valid = 1'b0;
      wait_res(0, n);
      total++;
      if ({res_id, res_less} !== 2'b01)
        $display("FAIL t3_res0 r%0d: got %b expected 01", round, {res_id, res_less});
      else passed++;
      step();
      total++; if (req1_ready !== 1'b1) $display("FAIL t3_grant1 r%0d: got %b expected 1", round, req1_ready); else passed++;
      step();
      req1_valid = 1'b0;
      wait_res(0, n);
      total++;
      if ({res_id, res_greater} !== 2'b11)
        $display("FAIL t3_res1 r%0d: got %b expected 11", round, {res_id, res_greater});
      else passed++;
      step();
    end
    total++; if (both_err != 0) $display("FAIL t3_both_ready: got %0d expected 0", both_err); else passed++;
  endtask

  task automatic test_backpressure();
    logic r; int n; int err;
    err = 0;
    res_ready = 1'b0;
    issue(0, 8'h10, 8'h20, r);
    wait_res(0, n);
    total++; if (n != 3) $display("FAIL t4_latency: got %0d expected 3", n); else passed++;
    req1_a = 8'h33; req1_b = 8'h33; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (res_valid !== 1'b1 || {res_less, res_eq, res_greater} !== 3'b100 || res_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) err++;
      step();
    end
    total++; if (err != 0) $display("FAIL t4_stable: got %0d bad cycles expected 0", err); else passed++;
    res_ready = 1'b1;
    #1;
    total++; if (req1_ready !== 1'b0) $display("FAIL t4_ready_done: got %b expected 0", req1_ready); else passed++;
    step();
    total++;
    if ({res_valid, res_id, res_less, res_eq, res_greater, busy} !== 6'b0)
      $display("FAIL t4_idle_outs: got %b expected 000000",
               {res_valid, res_id, res_less, res_eq, res_greater, busy});
    else passed++;
    total++; if (req1_ready !== 1'b1) $display("FAIL t4_ready_idle: got %b expected 1", req1_ready); else passed++;
    step();
    req1_valid = 1'b0;
    wait_res(0, n);
    total++;
    if ({n[7:0], res_id, res_eq} !== {8'd8, 2'b11})
      $display("FAIL t4_next: got lat %0d id %b eq %b expected lat 8 id 1 eq 1", n, res_id, res_eq);
    else passed++;
    step();
  endtask

  task automatic test_reset_mid();
    logic r; int n;
    issue(0, 8'h00, 8'h00, r);
    req1_a = 8'h01; req1_b = 8'h02; req1_valid = 1'b1;
    step(); step();
    total++; if (busy !== 1'b1) $display("FAIL t5_busy_pre: got %b expected 1", busy); else passed++;
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({res_valid, busy, req0_ready, req1_ready} !== 4'b0)
      $display("FAIL t5_async: got %b expected 0000", {res_valid, busy, req0_ready, req1_ready});
    else passed++;
    step();
    rst = 1'b1;
    req0_a = 8'h05; req0_b = 8'h03; req0_valid = 1'b1;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL t5_prio: got %b expected 10", {req0_ready, req1_ready});
    else passed++;
    step();
    req0_valid = 1'b0;
    wait_res(0, n);
    total++;
    if ({n[7:0], res_id, res_greater} !== {8'd6, 2'b01})
      $display("FAIL t5_res0: got lat %0d id %b gt %b expected 6 0 1", n, res_id, res_greater);
    else passed++;
    step();
    total++; if (req1_ready !== 1'b1) $display("FAIL t5_req1_ready: got %b expected 1", req1_ready); else passed++;
    step();
    req1_valid = 1'b0;
    wait_res(0, n);
    total++;
    if ({n[7:0], res_id, res_less} !== {8'd7, 2'b11})
      $display("FAIL t5_res1: got lat %0d id %b lt %b expected 7 1 1", n, res_id, res_less);
    else passed++;
    step();
  endtask

  task automatic test_early_exit_modes();
    logic r; int n;
    issue(2, 8'h80, 8'h00, r);
    wait_res(1, n);
    total++;
    if ({n[7:0], n_res_greater} !== {8'd8, 1'b1})
      $display("FAIL t6_ne_gt: got lat %0d gt %b expected 8 1", n, n_res_greater);
    else passed++;
    step();
    issue(0, 8'h80, 8'h00, r);
    wait_res(0, n);
    total++;
    if ({n[7:0], res_greater} !== {8'd1, 1'b1})
      $display("FAIL t6_ee_gt: got lat %0d gt %b expected 1 1", n, res_greater);
    else passed++;
    step();
    issue(2, 8'h00, 8'h01, r);
    wait_res(1, n);
    total++;
    if ({n[7:0], n_res_less} !== {8'd8, 1'b1})
      $display("FAIL t6_ne_lt: got lat %0d lt %b expected 8 1", n, n_res_less);
    else passed++;
    step();
    issue(0, 8'h00, 8'h01, r);
    wait_res(0, n);
    total++;
    if ({n[7:0], res_less} !== {8'd8, 1'b1})
      $display("FAIL t6_ee_lt: got lat %0d lt %b expected 8 1", n, res_less);
    else passed++;
    step();
  endtask

  initial begin
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    n_req0_valid = 1'b0; n_req1_valid = 1'b0;
    n_req0_a = '0; n_req0_b = '0; n_req1_a = '0; n_req1_b = '0;
    res_ready = 1'b1; n_res_ready = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_greater_early();
    test_equal_req1();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    test_early_exit_modes();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
